ram_loader: RTL and testbench
=============================

Name: ram_loader

Overview:
- Bus master for the single-port program RAM: accepts a byte stream over a valid/ready handshake and writes it to sequential addresses starting at 0.
- Reads the image back and checks an additive checksum, then releases the CPU through cpu_run.
- Sits between the host/serial front end and the RAM's clk/rw/addr/data_in/data_out port.

Parameters:
ADDR_WIDTH, 4, RAM address width; DEPTH = 2**ADDR_WIDTH words
DATA_WIDTH, 8, RAM word and stream byte width

Ports:
clk  input  1  system clock; RAM samples on negedge, loader on posedge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin load; honoured in IDLE, DONE, ERROR only
s_valid  input  1  stream word valid
s_data  input  DATA_WIDTH  stream word
s_last  input  1  marks final word of image (qualified by s_valid)
s_ready  output  1  loader accepts word this cycle
ram_rw  output  1  1 = write ram_data_in to ram_addr at next negedge
ram_addr  output  ADDR_WIDTH  RAM address
ram_data_in  output  DATA_WIDTH  write data to RAM
ram_data_out  input  DATA_WIDTH  read data from RAM, valid at posedge following address issue
busy  output  1  high in LOAD, VERIFY, CHECK
done  output  1  image verified
error  output  1  checksum mismatch
cpu_run  output  1  CPU release; high only in DONE
load_count  output  ADDR_WIDTH+1  number of words written in last load

Behaviour:
- States: IDLE, LOAD, VERIFY, CHECK, DONE, ERROR. All outputs are registered on posedge clk.
- Reset (rst_n low, asynchronous): state IDLE; all outputs 0. Internal pointer, wsum, rsum and load_count are 0. ram_rw drops immediately, so a mid-write reset aborts the write.
- Reset mid-load or mid-verify leaves partial RAM contents; no recovery is attempted.
- IDLE/DONE/ERROR + start=1:
  - go to LOAD; clear ptr, wsum, rsum, done, error, cpu_run.
  - start is ignored while busy.
- LOAD:
  - s_ready=1.
  - Handshake = s_valid & s_ready at posedge. Next cycle: ram_rw=1, ram_addr=ptr, ram_data_in=s_data. The RAM commits at the intervening negedge.
  - wsum += s_data (mod 2**DATA_WIDTH); ptr++.
  - Cycles with no handshake: ram_rw=0, and addr/data hold.
  - Leave LOAD when the accepted word has s_last=1 or ptr==DEPTH-1. load_count <= ptr+1 (1..DEPTH); s_ready=0 from that cycle.
  - Words beyond DEPTH are never accepted; no address wrap.
- VERIFY:
  - ram_rw=0.
  - Issue ram_addr=0..load_count-1, one per cycle.
  - Each read issued in cycle N is sampled from ram_data_out at the posedge ending cycle N+1; rsum += sample.
  - After the last address is issued, go to CHECK.
- CHECK:
  - One cycle to capture the final read.
  - Then compare rsum to wsum: equal -> DONE, else -> ERROR.
- Total verify time is load_count+1 cycles.
- DONE: done=1, cpu_run=1, busy=0. Outputs hold until start.
- ERROR: error=1, cpu_run=0, busy=0. Outputs hold until start.
- ram_rw is never high outside LOAD and is high for exactly one cycle per accepted word.
- s_last with s_valid=0 is ignored.
- s_last on the first word gives load_count=1.

Test Plan:
- Load 3 words 0x11,0x22,0x33 (s_last on 0x33), ideal RAM model -> 3 one-cycle ram_rw pulses at addr 0,1,2; load_count=3; verify reads addr 0..2; done=1, cpu_run=1, error=0 after 4 verify cycles.
- Stream 20 words with no s_last, ADDR_WIDTH=4 -> exactly 16 accepted; s_ready low after the 16th; load_count=16; addr never wraps; done=1.
- s_valid toggled 1/0 every cycle during load of 0x01..0x04 -> ram_rw only in cycles after handshakes; wsum=0x0A; done=1.
- RAM model corrupts addr 2 on readback (XOR 0x01) -> error=1, done=0, cpu_run=0; start re-runs load; with the fault removed -> done=1.
- Assert rst_n low mid-LOAD, coincident with ram_rw=1 -> ram_rw and all outputs 0 immediately; state IDLE; subsequent start loads cleanly from addr 0.
- start pulsed during VERIFY -> ignored; single-word image 0xFF with s_last -> load_count=1, done=1.

Source files
------------

// File: rtl/ram_loader_if.sv
// Bus bundle between the loader, the byte-stream source and the program RAM.
// Stream handshake: a word transfers on a rising clk edge where s_valid and
// s_ready are both high; s_data and s_last are only meaningful while s_valid
// is high, and the source holds them stable until the transfer happens.
// RAM port: ram_rw=1 writes ram_data_in to ram_addr at the next negedge;
// ram_data_out reflects ram_addr as sampled at the previous negedge.
interface ram_loader_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;
    logic                  s_ready;
    logic                  ram_rw;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_data_in;
    logic [DATA_WIDTH-1:0] ram_data_out;

    // Loader side: stream sink and RAM bus master.
    modport master (
        input  s_valid, s_data, s_last, ram_data_out,
        output s_ready, ram_rw, ram_addr, ram_data_in
    );

    // Environment side: stream source and the RAM itself.
    modport slave (
        output s_valid, s_data, s_last, ram_data_out,
        input  s_ready, ram_rw, ram_addr, ram_data_in
    );
endinterface

// File: rtl/ram_loader.sv
// Program RAM loader: writes a byte stream to addresses 0.. upward, reads the
// image back, compares additive checksums and releases the CPU on a match.
// A load ends on s_last or when the RAM is full. The write for the final word
// lands in one extra LOAD cycle with s_ready low, so ram_rw never leaves LOAD.
// Read-back: the address is registered in VERIFY cycle N and the data is
// summed at the edge ending cycle N+1; CHECK absorbs the last read.
module ram_loader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    ram_loader_if.master        bus,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic                cpu_run,
    output logic [ADDR_WIDTH:0] load_count,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        VERIFY = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH:0] LAST_PTR = (ADDR_WIDTH+1)'((2 ** ADDR_WIDTH) - 1);

    state_t                state;
    logic [ADDR_WIDTH:0]   ptr;
    logic [DATA_WIDTH-1:0] wsum;
    logic [DATA_WIDTH-1:0] rsum;
    logic                  load_tail;
    logic                  hs;
    logic [DATA_WIDTH-1:0] rsum_next;

    assign hs        = bus.s_valid & bus.s_ready;
    assign rsum_next = rsum + bus.ram_data_out;
    assign dbg_state = state;

    // Control FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            ptr             <= '0;
            wsum            <= '0;
            rsum            <= '0;
            load_tail       <= 1'b0;
            load_count      <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            cpu_run         <= 1'b0;
            bus.s_ready     <= 1'b0;
            bus.ram_rw      <= 1'b0;
            bus.ram_addr    <= '0;
            bus.ram_data_in <= '0;
        end else begin
            // Write strobe is a single-cycle pulse unless a word is accepted.
            bus.ram_rw <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state       <= LOAD;
                        ptr         <= '0;
                        wsum        <= '0;
                        rsum        <= '0;
                        load_tail   <= 1'b0;
                        done        <= 1'b0;
                        error       <= 1'b0;
                        cpu_run     <= 1'b0;
                        busy        <= 1'b1;
                        bus.s_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_tail) begin
                        // Final write is on the bus this cycle; start read-back next.
                        state     <= VERIFY;
                        ptr       <= '0;
                        load_tail <= 1'b0;
                    end else if (hs) begin
                        bus.ram_rw      <= 1'b1;
                        bus.ram_addr    <= ptr[ADDR_WIDTH-1:0];
                        bus.ram_data_in <= bus.s_data;
                        wsum            <= wsum + bus.s_data;
                        ptr             <= ptr + 1'b1;
                        if (bus.s_last || (ptr == LAST_PTR)) begin
                            load_count  <= ptr + 1'b1;
                            bus.s_ready <= 1'b0;
                            load_tail   <= 1'b1;
                        end
                    end
                end
                VERIFY: begin
                    bus.ram_addr <= ptr[ADDR_WIDTH-1:0];
                    if (ptr != '0) begin
                        rsum <= rsum_next;
                    end
                    ptr <= ptr + 1'b1;
                    if (ptr == (load_count - 1'b1)) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    rsum <= rsum_next;
                    busy <= 1'b0;
                    if (rsum_next == wsum) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        cpu_run <= 1'b1;
                    end else begin
                        state <= ERROR;
                        error <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader with a negedge-clocked RAM model, a write
// scoreboard and immediate-assertion checks.
module tb_ram_loader;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    logic start;

    always #5 clk = ~clk;

    logic          busy, done, error, cpu_run;
    logic [AW:0]   load_count;
    logic [2:0]    dbg_state;

    ram_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cpu_run    (cpu_run),
        .load_count (load_count),
        .dbg_state  (dbg_state)
    );

    // ---------------- RAM model + write monitor ----------------
    logic [DW-1:0]    mem [DEPTH];
    logic             fault_en;
    logic [AW+DW-1:0] obs_q[$];

    // Program RAM: write and read both happen on the falling edge.
    always @(negedge clk) begin
        if (rst_n && bus.ram_rw) begin
            mem[bus.ram_addr] <= bus.ram_data_in;
            obs_q.push_back({bus.ram_addr, bus.ram_data_in});
        end
        bus.ram_data_out <= mem[bus.ram_addr] ^
                            ((fault_en && (bus.ram_addr == 4'd2)) ? 8'h01 : 8'h00);
    end

    // ---------------- scoreboard ----------------
    int               checks;
    int               failures;
    logic [AW+DW-1:0] exp_q[$];
    int               obs_idx;
    int               exp_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_writes(input string tag);
        int cnt;
        cnt = obs_q.size() - obs_idx;
        check({tag, "_wr_count"}, 32'(cnt), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cnt; i++) begin
            check({tag, "_wr"}, 32'(obs_q[obs_idx + i]), 32'(exp_q[i]));
        end
        obs_idx = obs_q.size();
        exp_q.delete();
    endtask

    task automatic check_cleared(input string tag);
        check(tag, 32'({bus.s_ready, bus.ram_rw, bus.ram_addr, bus.ram_data_in,
                        busy, done, error, cpu_run, load_count, dbg_state}), 32'd0);
    endtask

    // ---------------- drivers ----------------
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_addr = 0;
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic last, input int limit,
                             output bit acc);
        logic          rdy;
        logic [AW-1:0] a;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        acc = 1'b0;
        for (int i = 0; i < limit && !acc; i++) begin
            @(negedge clk);
            rdy = bus.s_ready;
            @(posedge clk); #1;
            if (rdy) acc = 1'b1;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        if (acc) begin
            a = exp_addr[AW-1:0];
            exp_q.push_back({a, d});
            exp_addr++;
        end
    endtask

    task automatic wait_end(output int cyc);
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (done || error) break;
        end
        check("end_reached", 32'(done | error), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cyc;
        int n;
        bit acc;
        checks   = 0;
        failures = 0;
        obs_idx  = 0;
        exp_addr = 0;
        fault_en = 1'b0;
        rst_n    = 1'b0;
        start    = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset_state");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: three-word image 11,22,33
        pulse_start();
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_s_ready", 32'(bus.s_ready), 32'd1);
        send_word(8'h11, 1'b0, 5, acc);
        send_word(8'h22, 1'b0, 5, acc);
        send_word(8'h33, 1'b1, 5, acc);
        check("t1_last_rw", 32'(bus.ram_rw), 32'd1);
        check("t1_last_addr", 32'(bus.ram_addr), 32'd2);
        check("t1_ready_low", 32'(bus.s_ready), 32'd0);
        wait_end(cyc);
        check("t1_cycles", 32'(cyc), 32'd5);
        check("t1_flags", 32'({done, cpu_run, error, busy}), 32'b1100);
        check("t1_load_count", 32'(load_count), 32'd3);
        check_writes("t1");

        // 2: 20 words, no s_last; only DEPTH accepted
        pulse_start();
        check("t2_done_cleared", 32'({done, cpu_run, busy}), 32'b001);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            send_word(8'(8'h40 + i), 1'b0, 4, acc);
            if (acc) n++;
            if (n == 16 && i == 15) check("t2_ready_low", 32'(bus.s_ready), 32'd0);
        end
        check("t2_accepted", 32'(n), 32'd16);
        wait_end(cyc);
        check("t2_load_count", 32'(load_count), 32'd16);
        check("t2_done", 32'({done, error}), 32'b10);
        check_writes("t2");

        // 3: s_valid toggling, stray s_last while s_valid low
        pulse_start();
        for (int d = 1; d <= 4; d++) begin
            send_word(8'(d), (d == 4), 5, acc);
            if (d < 4) begin
                bus.s_last = 1'b1;
                @(posedge clk); #1;
                bus.s_last = 1'b0;
                check("t3_idle_rw", 32'(bus.ram_rw), 32'd0);
            end
        end
        wait_end(cyc);
        check("t3_load_count", 32'(load_count), 32'd4);
        check("t3_done", 32'({done, cpu_run, error}), 32'b110);
        check_writes("t3");

        // 4: read-back fault at addr 2, then clean rerun
        fault_en = 1'b1;
        pulse_start();
        send_word(8'h10, 1'b0, 5, acc);
        send_word(8'h20, 1'b0, 5, acc);
        send_word(8'h30, 1'b1, 5, acc);
        wait_end(cyc);
        check("t4_cycles", 32'(cyc), 32'd5);
        check("t4_error", 32'({done, cpu_run, error, busy}), 32'b0010);
        check_writes("t4a");
        fault_en = 1'b0;
        pulse_start();
        check("t4_error_cleared", 32'(error), 32'd0);
        send_word(8'h10, 1'b0, 5, acc);
        send_word(8'h20, 1'b0, 5, acc);
        send_word(8'h30, 1'b1, 5, acc);
        wait_end(cyc);
        check("t4_rerun", 32'({done, cpu_run, error}), 32'b110);
        check_writes("t4b");

        // 5: reset asserted while a write strobe is high
        pulse_start();
        send_word(8'hA1, 1'b0, 5, acc);
        check("t5_rw_before", 32'(bus.ram_rw), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_cleared("t5_reset_clear");
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        obs_idx = obs_q.size();
        @(posedge clk); #1;
        pulse_start();
        send_word(8'h5A, 1'b0, 5, acc);
        send_word(8'h5B, 1'b1, 5, acc);
        wait_end(cyc);
        check("t5_done", 32'({done, error}), 32'b10);
        check("t5_load_count", 32'(load_count), 32'd2);
        check_writes("t5");

        // 6: single-word image, start pulsed during VERIFY
        pulse_start();
        send_word(8'hFF, 1'b1, 5, acc);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("t6_state_check", 32'(dbg_state), 32'd3);
        check("t6_busy", 32'(busy), 32'd1);
        wait_end(cyc);
        check("t6_cycles", 32'(cyc), 32'd1);
        check("t6_load_count", 32'(load_count), 32'd1);
        check("t6_done", 32'({done, cpu_run, error}), 32'b110);
        check_writes("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
